// File: rtl/pipe_monitor_pkg.sv
// Shared definitions for the pipeline performance monitor: FSM encoding,
// default parameter values and the counter-select width helper.
package pipe_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DEF_CNT_W       = 32;
  localparam int DEF_N_EVT       = 2;
  localparam int DEF_MAX_CYCLES  = 30;
  localparam int DEF_TRACE_DEPTH = 8;
  localparam int DEF_TRACE_EVT   = 1;
  localparam int PC_W            = 32;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipe_monitor_trace_fifo.sv
// First-word fall-through PC trace buffer with sticky overflow flag.
// A push into a full buffer is accepted only when a pop frees a slot the same cycle.
module trace_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             ovf_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             ovf_r;
  logic             empty_s;
  logic             full_s;
  logic             pop_s;
  logic             push_s;
  logic             drop_s;

  // Qualify requests against the current occupancy.
  always_comb begin
    empty_s = (count_r == {(AW+1){1'b0}});
    full_s  = (count_r == FULL_CNT);
    pop_s   = pop_i & ~empty_s;
    push_s  = push_i & (~full_s | pop_s);
    drop_s  = push_i & full_s & ~pop_s;
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      ovf_r    <= 1'b0;
    end else if (clr_i) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      ovf_r    <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
      if (drop_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  // Storage array; contents are only observable through valid pointers.
  always_ff @(posedge clk_i) begin
    if (push_s & ~clr_i) begin
      mem_r[wr_ptr_r] <= data_i;
    end
  end

  assign data_o  = empty_s ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];
  assign empty_o = empty_s;
  assign ovf_o   = ovf_r;

endmodule

// File: rtl/pipe_monitor.sv
// Pipeline performance monitor: run-window FSM, saturating cycle/event counters
// and a PC trace of one selected event channel.
module pipe_monitor
  import pipe_monitor_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int N_EVT       = DEF_N_EVT,
  parameter int MAX_CYCLES  = DEF_MAX_CYCLES,
  parameter int TRACE_DEPTH = DEF_TRACE_DEPTH,
  parameter int TRACE_EVT   = DEF_TRACE_EVT,
  localparam int SEL_W      = sel_width(N_EVT)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic [PC_W-1:0]  pc_i,
  input  logic [N_EVT-1:0] evt_i,
  input  logic [SEL_W-1:0] rd_sel_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cycle_o,
  output logic [1:0]       state_o,
  output logic             done_o,
  input  logic             trace_rd_i,
  output logic [PC_W-1:0]  trace_pc_o,
  output logic             trace_valid_o,
  output logic             trace_ovf_o
);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CYC_LIMIT = CNT_W'(MAX_CYCLES);
  // A limit beyond the saturation value can never be reached.
  localparam bit LIMIT_ON = (MAX_CYCLES != 0) &&
                            (longint'(MAX_CYCLES) <= ((64'sd1 <<< CNT_W) - 64'sd1));

  state_e           state_r;
  state_e           state_nxt_s;
  logic [CNT_W-1:0] cycle_r;
  logic [CNT_W-1:0] cycle_nxt_s;
  logic [CNT_W-1:0] evt_cnt_r     [N_EVT];
  logic [CNT_W-1:0] evt_cnt_nxt_s [N_EVT];
  logic             done_r;
  logic             run_s;
  logic             capture_s;
  logic             pop_s;
  logic             empty_s;
  logic [CNT_W-1:0] cnt_sel_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Next-state and counter update; the edge leaving RUN is still counted.
  always_comb begin
    state_nxt_s = state_r;
    cycle_nxt_s = cycle_r;
    for (int k = 0; k < N_EVT; k++) begin
      evt_cnt_nxt_s[k] = evt_cnt_r[k];
    end
    run_s = (state_r == ST_RUN);

    if (clear_i) begin
      state_nxt_s = ST_IDLE;
      cycle_nxt_s = {CNT_W{1'b0}};
      for (int k = 0; k < N_EVT; k++) begin
        evt_cnt_nxt_s[k] = {CNT_W{1'b0}};
      end
    end else begin
      if (run_s) begin
        cycle_nxt_s = sat_inc(cycle_r);
        for (int k = 0; k < N_EVT; k++) begin
          evt_cnt_nxt_s[k] = evt_i[k] ? sat_inc(evt_cnt_r[k]) : evt_cnt_r[k];
        end
      end else begin
        cycle_nxt_s = cycle_r;
      end

      case (state_r)
        ST_IDLE:  state_nxt_s = start_i ? ST_RUN : ST_IDLE;
        ST_RUN: begin
          if (LIMIT_ON && (cycle_nxt_s == CYC_LIMIT)) begin
            state_nxt_s = ST_DONE;
          end else if (!start_i) begin
            state_nxt_s = ST_PAUSE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_PAUSE: state_nxt_s = start_i ? ST_RUN : ST_PAUSE;
        ST_DONE:  state_nxt_s = ST_DONE;
        default:  state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // State, counters and the registered done flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      cycle_r <= {CNT_W{1'b0}};
      done_r  <= 1'b0;
      for (int k = 0; k < N_EVT; k++) begin
        evt_cnt_r[k] <= {CNT_W{1'b0}};
      end
    end else begin
      state_r <= state_nxt_s;
      cycle_r <= cycle_nxt_s;
      done_r  <= (state_nxt_s == ST_DONE);
      for (int k = 0; k < N_EVT; k++) begin
        evt_cnt_r[k] <= evt_cnt_nxt_s[k];
      end
    end
  end

  // Counter read mux; selects past the last channel read as zero.
  always_comb begin
    cnt_sel_s = {CNT_W{1'b0}};
    for (int k = 0; k < N_EVT; k++) begin
      cnt_sel_s = (rd_sel_i == SEL_W'(k)) ? evt_cnt_r[k] : cnt_sel_s;
    end
  end

  assign capture_s = run_s & evt_i[TRACE_EVT] & ~clear_i;
  assign pop_s     = trace_rd_i & ~clear_i;

  trace_fifo #(
    .DEPTH (TRACE_DEPTH),
    .WIDTH (PC_W)
  ) u_trace (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (clear_i),
    .push_i  (capture_s),
    .pop_i   (pop_s),
    .data_i  (pc_i),
    .data_o  (trace_pc_o),
    .empty_o (empty_s),
    .ovf_o   (trace_ovf_o)
  );

  assign cnt_o         = cnt_sel_s;
  assign cycle_o       = cycle_r;
  assign state_o       = state_r;
  assign done_o        = done_r;
  assign trace_valid_o = ~empty_s;

endmodule
